// File: rtl/frame_pkg.sv
// Shared constants, state encoding and pixel type for the 320x240 RGB444
// frame writer.
package frame_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
   localparam int FB_AW     = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FLIP  = 2'd2,
      RETRY = 2'd3
   } state_t;

   // {R[11:8], G[7:4], B[3:0]}
   typedef logic [11:0] pixel_t;

endpackage

// File: rtl/frame_writer_flip_wait.sv
// Bank-flip watcher: remembers which bank was on screen when the frame ended
// and times out the swap request so it can be re-issued as a fresh edge.
module frame_writer_flip_wait
   import frame_pkg::*;
#(
   parameter int FLIP_TIMEOUT = 2000000
) (
   input  logic   clk_sys,
   input  logic   rst_n_sys,
   input  state_t state,
   input  logic   capture,
   input  logic   active_buf_sys,
   output logic   flip_seen,
   output logic   retry_pulse
);

   localparam int TW = (FLIP_TIMEOUT > 1) ? $clog2(FLIP_TIMEOUT) : 1;

   logic [TW-1:0] to_cnt;
   logic          flip_ref;

   always_ff @(posedge clk_sys) begin
      if (!rst_n_sys) begin
         to_cnt   <= '0;
         flip_ref <= 1'b0;
      end else begin
         if (capture) flip_ref <= active_buf_sys;
         // Cleared in every state but FLIP, so each RETRY restarts the window.
         if (state == FLIP) to_cnt <= to_cnt + 1'b1;
         else               to_cnt <= '0;
      end
   end

   assign flip_seen   = (state == FLIP) && (active_buf_sys != flip_ref);
   assign retry_pulse = (state == FLIP) && !flip_seen &&
                        (to_cnt == TW'(FLIP_TIMEOUT - 1));

endmodule

// File: rtl/frame_writer_320x240_rgb12.sv
// Streams one frame into the hidden bank, then holds a swap request until the
// displayed bank flips. Optional counters: define FRAME_WRITER_STATS_EN.
module frame_writer_320x240_rgb12
   import frame_pkg::*;
#(
   parameter int WIDTH        = FB_WIDTH,
   parameter int HEIGHT       = FB_HEIGHT,
   parameter int AW           = FB_AW,
   parameter int FLIP_TIMEOUT = 2000000
) (
   input  logic          clk_sys,
   input  logic          rst_n_sys,
   input  logic          s_valid,
   output logic          s_ready,
   input  pixel_t        s_data,
   input  logic          s_sof,
   input  logic          active_buf_sys,
   output logic          wr_en_sys,
   output logic [AW-1:0] wr_addr_sys,
   output pixel_t        wr_data_sys,
   output logic          swap_req_sys,
   output logic          busy,
   output logic          frame_done,
   output logic          sof_err
`ifdef FRAME_WRITER_STATS_EN
   ,
   output logic [15:0]   frame_count,
   output logic [15:0]   err_count,
   output logic [15:0]   retry_count
`endif
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

   state_t        state, state_nx;
   logic [AW-1:0] addr_cnt;
   logic          accept, wr_now, last_beat, restart;
   logic          flip_seen, retry_pulse, swap_nx;

   assign s_ready   = (state == IDLE) || (state == WRITE);
   assign busy      = (state != IDLE);
   assign accept    = s_valid && s_ready;
   assign wr_now    = accept && (s_sof || (state == WRITE));
   assign restart   = accept && (state == WRITE) && s_sof && (addr_cnt != '0);
   assign last_beat = accept && (state == WRITE) && !s_sof && (addr_cnt == LAST_ADDR);

   // NOTE: next-state gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && s_sof) state_nx = WRITE;
         WRITE:   if (last_beat)       state_nx = FLIP;
         FLIP:    if (flip_seen)        state_nx = IDLE;
                  else if (retry_pulse) state_nx = RETRY;
         RETRY:   state_nx = FLIP;
         default: state_nx = IDLE;
      endcase
   end

   // The first FLIP cycle is excluded so the request trails the last write.
   assign swap_nx = (state_nx == FLIP) && (state != WRITE);

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys) begin
      if (!rst_n_sys) begin
         state        <= IDLE;
         addr_cnt     <= '0;
         wr_en_sys    <= 1'b0;
         wr_addr_sys  <= '0;
         wr_data_sys  <= '0;
         swap_req_sys <= 1'b0;
         frame_done   <= 1'b0;
         sof_err      <= 1'b0;
      end else begin
         state        <= state_nx;
         wr_en_sys    <= wr_now;
         swap_req_sys <= swap_nx;
         frame_done   <= flip_seen;
         sof_err      <= restart;
         if (wr_now) begin
            wr_addr_sys <= s_sof ? '0 : addr_cnt;
            wr_data_sys <= s_data;
            if (s_sof)          addr_cnt <= AW'(1);
            else if (last_beat) addr_cnt <= '0;
            else                addr_cnt <= addr_cnt + 1'b1;
         end
      end
   end

   frame_writer_flip_wait #(
      .FLIP_TIMEOUT (FLIP_TIMEOUT)
   ) u_flip_wait (
      .clk_sys        (clk_sys),
      .rst_n_sys      (rst_n_sys),
      .state          (state),
      .capture        (last_beat),
      .active_buf_sys (active_buf_sys),
      .flip_seen      (flip_seen),
      .retry_pulse    (retry_pulse)
   );

`ifdef FRAME_WRITER_STATS_EN
   always_ff @(posedge clk_sys) begin
      if (!rst_n_sys) begin
         frame_count <= '0;
         err_count   <= '0;
         retry_count <= '0;
      end else begin
         if (flip_seen)   frame_count <= frame_count + 1'b1;
         if (restart)     err_count   <= err_count + 1'b1;
         if (retry_pulse) retry_count <= retry_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_frame_writer_320x240_rgb12.sv
// Directed bench: full frame with mid-frame restart, swap timeout/retry,
// flip handshake, drop/backpressure and resets, checked against a write queue.
module tb_frame_writer_320x240_rgb12;
   import frame_pkg::*;

   localparam int TO = 16;

   logic        clk_sys;
   logic        rst_n_sys;
   logic        s_valid;
   logic        s_ready;
   pixel_t      s_data;
   logic        s_sof;
   logic        active_buf_sys;
   logic        wr_en_sys;
   logic [16:0] wr_addr_sys;
   pixel_t      wr_data_sys;
   logic        swap_req_sys;
   logic        busy;
   logic        frame_done;
   logic        sof_err;
`ifdef FRAME_WRITER_STATS_EN
   logic [15:0] frame_count;
   logic [15:0] err_count;
   logic [15:0] retry_count;
`endif

   frame_writer_320x240_rgb12 #(
      .FLIP_TIMEOUT (TO)
   ) dut (
      .clk_sys        (clk_sys),
      .rst_n_sys      (rst_n_sys),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_sof          (s_sof),
      .active_buf_sys (active_buf_sys),
      .wr_en_sys      (wr_en_sys),
      .wr_addr_sys    (wr_addr_sys),
      .wr_data_sys    (wr_data_sys),
      .swap_req_sys   (swap_req_sys),
      .busy           (busy),
      .frame_done     (frame_done),
      .sof_err        (sof_err)
`ifdef FRAME_WRITER_STATS_EN
      ,
      .frame_count    (frame_count),
      .err_count      (err_count),
      .retry_count    (retry_count)
`endif
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [16:0] addr;
      pixel_t      data;
   } wr_t;

   wr_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   int          n_wr   = 0;
   state_t      m_state;
   logic [16:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_wr_en"},   32'(wr_en_sys),    32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr_sys),  32'd0);
      check({tag, "_wr_data"}, 32'(wr_data_sys),  32'd0);
      check({tag, "_swap"},    32'(swap_req_sys), 32'd0);
      check({tag, "_done"},    32'(frame_done),   32'd0);
      check({tag, "_sof_err"}, 32'(sof_err),      32'd0);
      check({tag, "_busy"},    32'(busy),         32'd0);
      check({tag, "_ready"},   32'(s_ready),      32'd1);
   endtask

   // One clock of stimulus; the model predicts acceptance and pushes the
   // expected write, which must appear right after the edge.
   task automatic step(input logic v, input logic sof, input pixel_t d);
      logic exp_ready;
      logic exp_err;
      wr_t  e;
      s_valid   = v;
      s_sof     = sof;
      s_data    = d;
      exp_ready = (m_state == IDLE) || (m_state == WRITE);
      exp_err   = 1'b0;
      check("s_ready", 32'(s_ready), 32'(exp_ready));
      if (v && exp_ready) begin
         if (sof) begin
            if (m_state == WRITE) exp_err = 1'b1;
            sb.push_back('{addr: 17'd0, data: d});
            m_cnt   = 17'd1;
            m_state = WRITE;
         end else if (m_state == WRITE) begin
            sb.push_back('{addr: m_cnt, data: d});
            if (m_cnt == 17'(FB_DEPTH - 1)) begin
               m_state = FLIP;
               m_cnt   = 17'd0;
            end else begin
               m_cnt = m_cnt + 17'd1;
            end
         end
      end
      @(posedge clk_sys);
      #1;
      check("wr_en", 32'(wr_en_sys), 32'(sb.size() != 0));
      if (wr_en_sys === 1'b1) n_wr++;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("wr_addr", 32'(wr_addr_sys), 32'(e.addr));
         check("wr_data", 32'(wr_data_sys), 32'(e.data));
      end
      check("sof_err", 32'(sof_err), 32'(exp_err));
   endtask

   initial begin
      rst_n_sys      = 1'b0;
      s_valid        = 1'b1;
      s_sof          = 1'b1;
      s_data         = 12'hABC;
      active_buf_sys = 1'b0;
      m_state        = IDLE;
      m_cnt          = 17'd0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk_sys);
         #1;
         check_idle("reset");
      end
      rst_n_sys = 1'b1;
      s_valid   = 1'b0;
      s_sof     = 1'b0;

      // Non-SOF beats in IDLE are consumed and dropped
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, pixel_t'($urandom_range(0, 4095)));
         check("drop_busy", 32'(busy), 32'd0);
      end

      // 500 beats, then a restarting SOF and a complete frame behind it
      step(1'b1, 1'b1, 12'hA5A);
      for (int i = 1; i < 500; i++) step(1'b1, 1'b0, 12'(i) ^ 12'hA5A);
      n_wr = 0;
      step(1'b1, 1'b1, 12'h000);
      for (int a = 1; a < FB_DEPTH; a++) begin
         if (a % 4096 == 0) step(1'b0, 1'b0, 12'hFFF);
         step(1'b1, 1'b0, 12'(a));
      end
      check("frame_writes", 32'(n_wr), 32'(FB_DEPTH));
      check("flip0_swap",  32'(swap_req_sys), 32'd0);
      check("flip0_ready", 32'(s_ready),      32'd0);
      check("flip0_busy",  32'(busy),         32'd1);

      // Held bank: request drops for one cycle on each retry (k = 16, 33)
      s_valid = 1'b1;
      s_sof   = 1'b0;
      s_data  = 12'hFFF;
      for (int k = 1; k <= 44; k++) begin
         @(posedge clk_sys);
         #1;
         check("flip_swap",  32'(swap_req_sys), 32'(!(k >= TO && (k - TO) % (TO + 1) == 0)));
         check("flip_wr_en", 32'(wr_en_sys),    32'd0);
         check("flip_ready", 32'(s_ready),      32'd0);
         check("flip_done",  32'(frame_done),   32'd0);
      end
`ifdef FRAME_WRITER_STATS_EN
      check("retry_count", 32'(retry_count), 32'd2);
`endif

      // Flip lands 10 cycles after the last rising edge of the request
      active_buf_sys = 1'b1;
      @(posedge clk_sys);
      #1;
      check("done_swap",  32'(swap_req_sys), 32'd0);
      check("done_pulse", 32'(frame_done),   32'd1);
      check("done_busy",  32'(busy),         32'd0);
      check("done_ready", 32'(s_ready),      32'd1);
      @(posedge clk_sys);
      #1;
      check("done_width", 32'(frame_done), 32'd0);
      check("done_wr_en", 32'(wr_en_sys),  32'd0);
`ifdef FRAME_WRITER_STATS_EN
      check("frame_count", 32'(frame_count), 32'd1);
      check("err_count",   32'(err_count),   32'd1);
`endif
      s_valid = 1'b0;
      m_state = IDLE;
      m_cnt   = 17'd0;

      // Next frame starts from address 0, then reset aborts it
      step(1'b1, 1'b1, 12'h123);
      step(1'b1, 1'b0, 12'h456);
      rst_n_sys = 1'b0;
      s_valid   = 1'b1;
      s_sof     = 1'b0;
      @(posedge clk_sys);
      #1;
      check_idle("midreset");
`ifdef FRAME_WRITER_STATS_EN
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_retry_count", 32'(retry_count), 32'd0);
`endif
      rst_n_sys = 1'b1;
      s_valid   = 1'b0;
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_writer_320x240_rgb12.md
Name: frame_writer_320x240_rgb12

Overview:
Upstream producer stage for the 320x240 RGB444 double-buffered image store. It accepts a pixel stream with valid/ready handshake in the clk_sys domain and writes one full frame linearly into the inactive bank. It then requests a buffer swap and waits until the displayed bank actually flips before accepting the next frame, so the bank on screen is never overwritten.

Parameters:
WIDTH, 320, pixels per line
HEIGHT, 240, lines per frame
AW, 17, write address width (must hold WIDTH*HEIGHT-1)
FLIP_TIMEOUT, 2000000, clk_sys cycles to wait for a bank flip before retrying the swap request

Ports:
clk_sys  in  1  system clock; the only clock
rst_n_sys  in  1  reset, synchronous, active-low
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel ready
s_data  in  12  pixel {R[11:8],G[7:4],B[3:0]}
s_sof  in  1  qualifies the beat as the first pixel of a frame
active_buf_sys  in  1  bank currently displayed, already synchronized into clk_sys
wr_en_sys  out  1  framebuffer write strobe
wr_addr_sys  out  AW  linear write address, 0..WIDTH*HEIGHT-1
wr_data_sys  out  12  write data
swap_req_sys  out  1  swap request level, held until the flip is observed
busy  out  1  high when the state is not IDLE
frame_done  out  1  1-cycle pulse when a flip is confirmed
sof_err  out  1  1-cycle pulse when a frame is restarted mid-frame

Behaviour:
- Reset (rst_n_sys=0 at a clk_sys edge):
  - state=IDLE; address counter=0.
  - wr_en_sys=0, wr_addr_sys=0, wr_data_sys=0.
  - swap_req_sys=0, frame_done=0, sof_err=0, busy=0.
  - Reset mid-frame or mid-flip aborts immediately; the partial frame is discarded.
- Beat accepted = s_valid & s_ready.
- s_ready is combinational from state: 1 in IDLE and WRITE, 0 in FLIP and RETRY.
- Write latency: wr_en_sys, wr_addr_sys and wr_data_sys are registered and appear 1 cycle after the accepted beat. wr_en_sys=0 otherwise; wr_addr_sys and wr_data_sys hold their last values.
- IDLE:
  - Accepted beat with s_sof=1: write it at address 0, counter=1, go to WRITE.
  - Accepted beat with s_sof=0: dropped, no write.
- WRITE:
  - Accepted beat with s_sof=0: write at the counter value, counter+1.
  - Accepted beat with s_sof=1 and counter!=0: pulse sof_err, write that pixel at address 0, counter=1 (restart the frame).
  - Beat written at WIDTH*HEIGHT-1 (76799): capture flip_ref=active_buf_sys and enter FLIP on the next cycle. The counter never exceeds 76799; there is no wrap into the next frame.
- FLIP:
  - swap_req_sys=1 (registered), first high 2 cycles after the last beat was accepted.
  - Timeout counter increments each cycle.
  - If active_buf_sys != flip_ref: swap_req_sys=0 next cycle, frame_done pulses, go to IDLE.
  - Else if timeout reaches FLIP_TIMEOUT-1: go to RETRY.
- RETRY:
  - One cycle with swap_req_sys=0; the timeout counter clears; return to FLIP.
  - This gives a fresh rising edge for the pixel-domain edge detector.
- Simultaneous flip observed and timeout expiry: the flip wins.
- active_buf_sys changing while in IDLE or WRITE: ignored. The bank select downstream follows active_buf_sys on its own.

Optional Feature:
FRAME_WRITER_STATS_EN
- Defined:
  - Adds outputs frame_count[15:0] (increments on frame_done), err_count[15:0] (increments on sof_err) and retry_count[15:0] (increments on RETRY entry).
  - All three wrap at 16 bits and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package frame_pkg holds:
  - constants FB_WIDTH=320, FB_HEIGHT=240, FB_DEPTH=76800, FB_AW=17;
  - the state encoding: IDLE=2'd0, WRITE=2'd1, FLIP=2'd2, RETRY=2'd3;
  - the RGB444 pixel typedef (12 bits).
- One sub-module is natural: frame_writer_flip_wait, containing the FLIP/RETRY timeout counter and the flip_ref compare. It outputs flip_seen and retry_pulse.

Test Plan:
- Reset: hold rst_n_sys=0 for 3 cycles with s_valid=1 -> all outputs 0, s_ready=1, no writes.
- Full frame: 76800 beats, s_sof on the first beat, data=addr[11:0] -> 76800 writes, addresses 0..76799 in order with data matching; swap_req_sys rises 2 cycles after the last accept; s_ready=0 afterwards.
- Flip handshake: toggle active_buf_sys 10 cycles after swap_req_sys rises -> swap_req_sys falls next cycle, frame_done=1 for exactly 1 cycle, busy=0, s_ready=1.
- Mid-frame restart: s_sof asserted on beat 500 -> sof_err pulse, that pixel written at address 0, the frame completes after 76800 further-counted beats starting from that SOF.
- Timeout retry: FLIP_TIMEOUT=16, active_buf_sys held constant -> swap_req_sys low for 1 cycle every 17 cycles; after toggling active_buf_sys, frame_done pulses; retry_count increments per retry when FRAME_WRITER_STATS_EN is defined.
- Backpressure and drop: beats with s_sof=0 in IDLE produce no writes; beats presented during FLIP see s_ready=0 and are not consumed.
